cpu_result_checker: RTL and testbench
=====================================

# cpu_result_checker

Synthesisable, parametrised result checker that watches one CPU register-write tap and compares each write against a programmable table of expected values. It replaces the fixed-delay, simulation-only checking of the current bench with event-driven checking usable on hardware and in simulation. It sits beside `cpu_core`, snooping its register write port and `PC_out`. It reports pass/fail, first-failure details and a watchdog timeout.

## Interface
Parameters:
- `DATA_W`, 16, width of the tapped register data and of expected values
- `PC_W`, 5, width of the program counter tap
- `DEPTH`, 16, number of expected-value entries; must be at least 2
- `TIMEOUT`, 64, maximum number of cycles allowed between tap writes while in RUN
- `STOP_ON_FAIL`, 1, 1 = stop at the first mismatch; 0 = run all entries and count failures

Ports:
- `clock`, in, 1, single clock; all logic is rising-edge
- `reset`, in, 1, synchronous, active-low
- `exp_we`, in, 1, write strobe into the expected table; accepted only in IDLE
- `exp_addr`, in, $clog2(DEPTH), table write address
- `exp_data`, in, DATA_W, expected value to store
- `num_checks`, in, $clog2(DEPTH)+1, number of entries to check, in the range 1..DEPTH; sampled on `start`
- `start`, in, 1, one-cycle pulse; accepted only in IDLE
- `tap_valid`, in, 1, register write strobe from the core
- `tap_data`, in, DATA_W, value written by the core
- `pc`, in, PC_W, core PC at the moment of the tap
- `busy`, out, 1, high while in RUN
- `done`, out, 1, high while in DONE
- `pass`, out, 1, high in DONE when every check matched and no timeout occurred
- `fail_idx`, out, $clog2(DEPTH), index of the first mismatch
- `fail_data`, out, DATA_W, observed value at the first mismatch
- `fail_pc`, out, PC_W, PC at the first mismatch
- `err_count`, out, $clog2(DEPTH)+1, total mismatches; saturates at DEPTH
- `timeout`, out, 1, watchdog fired

## Operation
- Reset: all outputs are 0 and the state is IDLE. The expected table is not cleared.
- IDLE:
  - `exp_we` writes `exp_data` into `exp_addr`.
  - `start` latches `num_checks`, clears the index counter, `err_count`, `timeout` and the first-failure registers, then moves to RUN.
  - If `start` and `exp_we` are asserted in the same cycle, both take effect. The write lands before the first compare.
- RUN:
  - Each `tap_valid` compares `tap_data` against `table[idx]`, then increments `idx`.
  - On a mismatch, `err_count` increments. `fail_idx`, `fail_data` and `fail_pc` capture only the first mismatch.
  - A mismatch with `STOP_ON_FAIL`=1 moves the block to DONE.
  - Once `idx` reaches `num_checks`-1 and that entry is compared, the block moves to DONE.
  - `exp_we` is ignored in RUN. `start` is ignored in RUN.
- Watchdog:
  - The counter clears on entry to RUN and on every `tap_valid`.
  - When it reaches TIMEOUT, the block sets `timeout` and moves to DONE.
  - If `tap_valid` arrives in the same cycle the counter reaches TIMEOUT, the compare wins and the counter clears.
- DONE:
  - `pass` = (`err_count`==0) && !`timeout`.
  - All results hold until the next `start`.
  - A `start` in DONE behaves as it does in IDLE: it clears results and moves to RUN.
  - `exp_we` is accepted in DONE.
- Reset mid-RUN: the run aborts, the block returns to IDLE and all outputs clear.

## Timing
- Compare is registered. `err_count` and the fail registers update 1 cycle after `tap_valid`.
- `done` rises 1 cycle after the final compare or the mismatch cycle, i.e. 1 cycle after the terminating `tap_valid`.
- `busy` rises the cycle after `start` and falls in the same cycle `done` rises.
- Table writes take 1 cycle. A read in the next cycle returns the new value.
- Back-to-back `tap_valid` on every cycle is supported at full rate.
- Timeout: `timeout` and `done` assert exactly TIMEOUT+1 cycles after the last `tap_valid`, or after `start` if no tap has arrived.

## Structure
- `cpu_chk_pkg` contains:
  - the state enum `chk_state_t` {IDLE, RUN, DONE}
  - the default parameter constants
  - the `chk_result_t` struct {pass, timeout, err_count, fail_idx, fail_data, fail_pc}
- Sub-module `chk_watchdog` is a parametrised TIMEOUT counter with `clear` and `enable` inputs and a `fired` output.
- The expected table is an inferred register array of DEPTH×DATA_W, written synchronously and read asynchronously by `idx`.

## Test plan
- All pass:
  - Stimulus: load the table with 6,1,15,9,3,4,13,9,1,0,6,7,64,16,1,4; set `num_checks`=16; drive matching taps 4 cycles apart.
  - Required response: `done` 1 cycle after the 16th tap, `pass`=1, `err_count`=0.
- Stop on fail:
  - Stimulus: `STOP_ON_FAIL`=1; the 4th tap writes 8 instead of 9 at `pc`=10.
  - Required response: `done` 1 cycle later, `fail_idx`=3, `fail_data`=8, `fail_pc`=10, `err_count`=1, `pass`=0.
- Run all:
  - Stimulus: `STOP_ON_FAIL`=0; mismatches at indices 2 and 12.
  - Required response: the run completes all 16 checks, `err_count`=2, `fail_idx`=2.
- Timeout:
  - Stimulus: `TIMEOUT`=64; 5 good taps, then silence.
  - Required response: `timeout`=1 and `done` exactly 65 cycles after the 5th tap, `pass`=0.
- Edge and back-to-back:
  - Stimulus: `num_checks`=1 with a single matching tap; then `start` again from DONE with taps on consecutive cycles.
  - Required response: results clear on `start`; every tap is checked with none dropped.
- Reset mid-run:
  - Stimulus: drive `reset` low after 3 taps.
  - Required response: next cycle, `busy`=0, `done`=0 and `err_count`=0; table contents are retained, so a re-run passes.

Source files
------------

// File: rtl/cpu_chk_pkg.sv
// Shared types and default parameters for the CPU register-write result checker.
package cpu_chk_pkg;

  localparam int CHK_DATA_W       = 16;
  localparam int CHK_PC_W         = 5;
  localparam int CHK_DEPTH        = 16;
  localparam int CHK_TIMEOUT      = 64;
  localparam int CHK_STOP_ON_FAIL = 1;
  localparam int CHK_IDX_W        = $clog2(CHK_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } chk_state_t;

  typedef struct packed {
    logic                  pass;
    logic                  timeout;
    logic [CHK_IDX_W:0]    err_count;
    logic [CHK_IDX_W-1:0]  fail_idx;
    logic [CHK_DATA_W-1:0] fail_data;
    logic [CHK_PC_W-1:0]   fail_pc;
  } chk_result_t;

endpackage

// File: rtl/chk_watchdog.sv
// Inactivity counter: counts enabled cycles since the last clear and flags when TIMEOUT is reached.
module chk_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic fired
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;

  // Saturate at the limit so a stalled block keeps firing until it leaves RUN.
  always_comb begin
    cnt_d = cnt_q;
    if (clear)                        cnt_d = '0;
    else if (enable && cnt_q != LIMIT) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign fired = enable && (cnt_q == LIMIT);

endmodule

// File: rtl/cpu_result_checker.sv
// Snoops a CPU register-write tap and compares each write against a programmable expected table.
module cpu_result_checker
  import cpu_chk_pkg::*;
#(
  parameter int DATA_W       = CHK_DATA_W,
  parameter int PC_W         = CHK_PC_W,
  parameter int DEPTH        = CHK_DEPTH,
  parameter int TIMEOUT      = CHK_TIMEOUT,
  parameter int STOP_ON_FAIL = CHK_STOP_ON_FAIL
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       exp_we,
  input  logic [$clog2(DEPTH)-1:0]   exp_addr,
  input  logic [DATA_W-1:0]          exp_data,
  input  logic [$clog2(DEPTH):0]     num_checks,
  input  logic                       start,
  input  logic                       tap_valid,
  input  logic [DATA_W-1:0]          tap_data,
  input  logic [PC_W-1:0]            pc,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [$clog2(DEPTH)-1:0]   fail_idx,
  output logic [DATA_W-1:0]          fail_data,
  output logic [PC_W-1:0]            fail_pc,
  output logic [$clog2(DEPTH):0]     err_count,
  output logic                       timeout
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [IW:0] ERR_MAX = (IW+1)'(DEPTH);

  chk_state_t        state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [IW:0]       n_q, n_d;
  logic [IW:0]       err_q, err_d;
  logic [IW-1:0]     fail_idx_q, fail_idx_d;
  logic [DATA_W-1:0] fail_data_q, fail_data_d;
  logic [PC_W-1:0]   fail_pc_q, fail_pc_d;
  logic              timeout_q, timeout_d;
  logic              pass_q, pass_d;
  logic              busy_q, done_q;

  logic [DATA_W-1:0] tbl_q [DEPTH];

  logic accept_start, tbl_we, hit, mism, last, wd_fired;

  assign accept_start = start && (state_q != RUN);
  assign tbl_we       = exp_we && (state_q != RUN);
  assign hit          = tap_valid && (state_q == RUN);
  assign mism         = tap_data != tbl_q[idx_q];
  assign last         = {1'b0, idx_q} == (n_q - 1'b1);

  // A write issued together with start lands here before any compare can occur in RUN.
  always_ff @(posedge clock) begin
    if (tbl_we) tbl_q[exp_addr] <= exp_data;
  end

  chk_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clock  (clock),
    .reset  (reset),
    .clear  (accept_start || hit),
    .enable (state_q == RUN),
    .fired  (wd_fired)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    n_d         = n_q;
    err_d       = err_q;
    fail_idx_d  = fail_idx_q;
    fail_data_d = fail_data_q;
    fail_pc_d   = fail_pc_q;
    timeout_d   = timeout_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          n_d         = num_checks;
          idx_d       = '0;
          err_d       = '0;
          fail_idx_d  = '0;
          fail_data_d = '0;
          fail_pc_d   = '0;
          timeout_d   = 1'b0;
          state_d     = RUN;
        end
      end
      RUN: begin
        // A tap in the same cycle the watchdog fires is still compared.
        if (tap_valid) begin
          idx_d = idx_q + 1'b1;
          if (mism) begin
            if (err_q != ERR_MAX) err_d = err_q + 1'b1;
            if (err_q == '0) begin
              fail_idx_d  = idx_q;
              fail_data_d = tap_data;
              fail_pc_d   = pc;
            end
          end
          if (last || (mism && STOP_ON_FAIL != 0)) state_d = DONE;
        end else if (wd_fired) begin
          timeout_d = 1'b1;
          state_d   = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
    pass_d = (state_d == DONE) && (err_d == '0) && !timeout_d;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      n_q         <= '0;
      err_q       <= '0;
      fail_idx_q  <= '0;
      fail_data_q <= '0;
      fail_pc_q   <= '0;
      timeout_q   <= 1'b0;
      pass_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      n_q         <= n_d;
      err_q       <= err_d;
      fail_idx_q  <= fail_idx_d;
      fail_data_q <= fail_data_d;
      fail_pc_q   <= fail_pc_d;
      timeout_q   <= timeout_d;
      pass_q      <= pass_d;
      busy_q      <= (state_d == RUN);
      done_q      <= (state_d == DONE);
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_idx  = fail_idx_q;
  assign fail_data = fail_data_q;
  assign fail_pc   = fail_pc_q;
  assign err_count = err_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_cpu_result_checker.sv
// Randomised bench: two checkers (stop-on-fail and run-all) share stimulus and are compared every cycle to a model.
module tb_cpu_result_checker;

  localparam int TO = 64;

  logic        clock = 1'b0;
  logic        reset;
  logic        exp_we;
  logic [3:0]  exp_addr;
  logic [15:0] exp_data;
  logic [4:0]  num_checks;
  logic        start;
  logic        tap_valid;
  logic [15:0] tap_data;
  logic [4:0]  pc;

  logic        s_busy, s_done, s_pass, s_timeout, a_busy, a_done, a_pass, a_timeout;
  logic [3:0]  s_fidx, a_fidx;
  logic [15:0] s_fdata, a_fdata;
  logic [4:0]  s_fpc, a_fpc, s_err, a_err;

  always #5 clock = ~clock;

  cpu_result_checker #(.DATA_W(16), .PC_W(5), .DEPTH(16), .TIMEOUT(TO), .STOP_ON_FAIL(1)) u_stop (
    .clock(clock), .reset(reset), .exp_we(exp_we), .exp_addr(exp_addr), .exp_data(exp_data),
    .num_checks(num_checks), .start(start), .tap_valid(tap_valid), .tap_data(tap_data), .pc(pc),
    .busy(s_busy), .done(s_done), .pass(s_pass), .fail_idx(s_fidx), .fail_data(s_fdata),
    .fail_pc(s_fpc), .err_count(s_err), .timeout(s_timeout));

  cpu_result_checker #(.DATA_W(16), .PC_W(5), .DEPTH(16), .TIMEOUT(TO), .STOP_ON_FAIL(0)) u_all (
    .clock(clock), .reset(reset), .exp_we(exp_we), .exp_addr(exp_addr), .exp_data(exp_data),
    .num_checks(num_checks), .start(start), .tap_valid(tap_valid), .tap_data(tap_data), .pc(pc),
    .busy(a_busy), .done(a_done), .pass(a_pass), .fail_idx(a_fidx), .fail_data(a_fdata),
    .fail_pc(a_fpc), .err_count(a_err), .timeout(a_timeout));

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: run mode 0=idle 1=running 2=finished, per checker (0=stop-on-fail, 1=run-all).
  int mst[2], midx[2], mn[2], merr[2], mfi[2], mfd[2], mfp[2], mto[2], mlast[2];
  int mtbl[2][16];
  int cyc = 0;

  always @(posedge clock) begin
    cyc++;
    for (int s = 0; s < 2; s++) begin
      if (!reset) begin
        mst[s] = 0; merr[s] = 0; mfi[s] = 0; mfd[s] = 0; mfp[s] = 0; mto[s] = 0; midx[s] = 0;
      end else if (mst[s] != 1) begin
        if (exp_we) mtbl[s][exp_addr] = exp_data;
        if (start) begin
          mn[s] = num_checks; midx[s] = 0; merr[s] = 0; mfi[s] = 0; mfd[s] = 0; mfp[s] = 0;
          mto[s] = 0; mst[s] = 1; mlast[s] = cyc;
        end
      end else if (tap_valid) begin
        bit bad;
        bad = (tap_data != mtbl[s][midx[s] % 16]);
        if (bad) begin
          if (merr[s] == 0) begin mfi[s] = midx[s]; mfd[s] = tap_data; mfp[s] = pc; end
          if (merr[s] < 16) merr[s]++;
        end
        midx[s]++;
        mlast[s] = cyc;
        if (midx[s] == mn[s] || (bad && s == 0)) mst[s] = 2;
      end else if (cyc - mlast[s] > TO) begin
        mto[s] = 1; mst[s] = 2;
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("s_busy", s_busy, mst[0] == 1);
      chk("s_done", s_done, mst[0] == 2);
      chk("s_pass", s_pass, mst[0] == 2 && merr[0] == 0 && mto[0] == 0);
      chk("s_err", s_err, merr[0]);
      chk("s_fidx", s_fidx, mfi[0]);
      chk("s_fdata", s_fdata, mfd[0]);
      chk("s_fpc", s_fpc, mfp[0]);
      chk("s_timeout", s_timeout, mto[0]);
      chk("a_busy", a_busy, mst[1] == 1);
      chk("a_done", a_done, mst[1] == 2);
      chk("a_pass", a_pass, mst[1] == 2 && merr[1] == 0 && mto[1] == 0);
      chk("a_err", a_err, merr[1]);
      chk("a_fidx", a_fidx, mfi[1]);
      chk("a_fdata", a_fdata, mfd[1]);
      chk("a_fpc", a_fpc, mfp[1]);
      chk("a_timeout", a_timeout, mto[1]);
    end
  end

  task automatic wr(input int a, input int d);
    exp_we = 1'b1; exp_addr = a[3:0]; exp_data = d[15:0];
    @(negedge clock);
    exp_we = 1'b0;
  endtask

  task automatic go(input int n);
    num_checks = n[4:0]; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic tap(input int d, input int p);
    tap_valid = 1'b1; tap_data = d[15:0]; pc = p[4:0];
    @(negedge clock);
    tap_valid = 1'b0;
  endtask

  task automatic idle(input int k);
    repeat (k) @(negedge clock);
  endtask

  int T[16] = '{6, 1, 15, 9, 3, 4, 13, 9, 1, 0, 6, 7, 64, 16, 1, 4};

  initial begin
    int k;
    reset = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_data = '0; num_checks = '0;
    start = 1'b0; tap_valid = 1'b0; tap_data = '0; pc = '0;
    idle(3);
    chk_en = 1;
    chk("rst_busy", s_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_err", s_err, 0);
    reset = 1'b1;
    idle(1);

    // All pass, taps four cycles apart.
    for (int i = 0; i < 16; i++) wr(i, T[i]);
    go(16);
    for (int i = 0; i < 16; i++) begin
      tap(T[i], i);
      if (i == 14) chk("allpass_busy_before_last", s_busy, 1);
      if (i < 15) idle(3);
    end
    chk("allpass_done", s_done, 1);
    chk("allpass_pass", s_pass, 1);
    chk("allpass_err", a_err, 0);
    idle(2);

    // Stop on fail: index 3 sees 8 at pc 10.
    go(16);
    for (int i = 0; i < 16; i++) begin
      tap((i == 3) ? 8 : T[i], (i == 3) ? 10 : i);
      if (i == 3) begin
        chk("sof_done", s_done, 1);
        chk("sof_fidx", s_fidx, 3);
        chk("sof_fdata", s_fdata, 8);
        chk("sof_fpc", s_fpc, 10);
        chk("sof_err", s_err, 1);
        chk("sof_pass", s_pass, 0);
        chk("sof_all_still_busy", a_busy, 1);
      end
    end
    chk("sof_all_err", a_err, 1);
    idle(2);

    // Run all: mismatches at 2 and 12; start must clear prior results.
    go(16);
    chk("start_clears_err", a_err, 0);
    chk("start_busy", a_busy, 1);
    for (int i = 0; i < 16; i++) tap((i == 2 || i == 12) ? (T[i] ^ 1) : T[i], i);
    chk("runall_done", a_done, 1);
    chk("runall_err", a_err, 2);
    chk("runall_fidx", a_fidx, 2);
    chk("runall_pass", a_pass, 0);
    idle(2);

    // Timeout after 5 good taps.
    go(16);
    for (int i = 0; i < 5; i++) tap(T[i], i);
    k = 0;
    while (!s_done && k < 200) begin @(negedge clock); k++; end
    chk("timeout_latency", k, 65);
    chk("timeout_flag", s_timeout, 1);
    chk("timeout_pass", s_pass, 0);
    chk("timeout_all_flag", a_timeout, 1);
    idle(2);

    // Single-entry run, then restart from DONE with back-to-back taps.
    go(1);
    tap(T[0], 0);
    chk("one_done", s_done, 1);
    chk("one_pass", s_pass, 1);
    go(16);
    for (int i = 0; i < 16; i++) begin
      tap(T[i], i);
      if (i == 14) chk("b2b_busy", a_busy, 1);
    end
    chk("b2b_done", a_done, 1);
    chk("b2b_pass", a_pass, 1);
    idle(2);

    // Randomised runs: random gaps, mismatches, stray writes/starts, occasional stall.
    for (int r = 0; r < 25; r++) begin
      if ($urandom_range(0, 2) == 0) wr($urandom_range(0, 15), $urandom_range(0, 65535));
      go($urandom_range(1, 16));
      for (int j = 0; j < 18; j++) begin
        idle(($urandom_range(0, 11) == 0) ? 70 : $urandom_range(0, 3));
        if ($urandom_range(0, 9) == 0) begin
          exp_we = 1'b1; exp_addr = 4'($urandom_range(0, 15)); exp_data = 16'($urandom_range(0, 65535));
        end
        if ($urandom_range(0, 14) == 0) begin
          start = 1'b1; num_checks = 5'($urandom_range(1, 16));
        end
        tap(($urandom_range(0, 3) == 0) ? $urandom_range(0, 65535) : mtbl[1][midx[1] % 16],
            $urandom_range(0, 31));
        exp_we = 1'b0; start = 1'b0;
      end
      idle(2);
    end
    idle(70);

    // Reset mid-run keeps the table.
    for (int i = 0; i < 16; i++) wr(i, T[i]);
    go(16);
    tap(T[0], 0);
    tap(T[1], 1);
    tap(T[2] ^ 4, 2);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    chk("rstmid_busy", s_busy, 0);
    chk("rstmid_done", s_done, 0);
    chk("rstmid_err", s_err, 0);
    chk("rstmid_all_err", a_err, 0);
    go(16);
    for (int i = 0; i < 16; i++) tap(T[i], i);
    chk("rerun_pass_stop", s_pass, 1);
    chk("rerun_pass_all", a_pass, 1);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
